// File: rtl/pipes_sqdiff_pipe.sv
// Four-stage, multi-lane (a+b)^2 / (a-b)^2 pipeline producing IEEE-754 single
// results. Lanes run in lockstep and share one valid bit per stage. A stalled
// output freezes every stage, so nothing is lost, duplicated or reordered.
module pipes_sqdiff_pipe #(
  parameter int LANES = 16,
  parameter int IN_W  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  output logic                    IN_RDY,
  input  logic                    MODE,
  input  logic [LANES*IN_W-1:0]   vals0,
  input  logic [LANES*IN_W-1:0]   vals1,
  output logic [LANES*32-1:0]     pipeout,
  output logic                    OUT_VLD,
  input  logic                    OUT_RDY,
  output logic [LANES-1:0]        inexact
);

  localparam int SUM_W = IN_W + 1;        // a +/- b never overflows here
  localparam int SQ_W  = 2 * IN_W + 2;    // holds (2^IN_W)^2 exactly
  localparam int POS_W = $clog2(SQ_W);    // bit index of the leading one
  localparam int EXT_W = SQ_W + 26;       // zero padding so narrow squares still yield guard/sticky bits

  logic       w_stall;
  logic       w_adv;
  logic [3:0] r_vld;                      // r_vld[k] = stage k+1 holds a valid beat

  assign w_stall = OUT_VLD & ~OUT_RDY;
  assign w_adv   = ~w_stall;
  // Reset overrides a stall so the upstream side is never blocked during reset.
  assign IN_RDY  = RST | w_adv;
  assign OUT_VLD = r_vld[3];

  // Valid-bit shift register: moves one stage per unstalled cycle, bubbles included.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge CLK) begin
    if (RST)        r_vld <= '0;
    else if (w_adv) r_vld <= {r_vld[2:0], EN};
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Lane 0 occupies the most significant slice of every packed bus.
    localparam int IN_LO  = (LANES - 1 - l) * IN_W;
    localparam int OUT_LO = (LANES - 1 - l) * 32;

    logic signed [IN_W-1:0]  w_a, w_b;
    logic signed [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0]        w_mag;
    logic [SQ_W-1:0]         r_sq;
    logic [POS_W-1:0]        w_pos;
    logic [POS_W-1:0]        w_shamt;
    logic [SQ_W-1:0]         r_norm;
    logic [7:0]              r_exp;
    logic                    r_nz;
    logic [EXT_W-1:0]        w_ext;
    logic [23:0]             w_man;
    logic                    w_guard, w_sticky, w_up;
    logic [24:0]             w_rnd;
    logic [7:0]              w_exp_fin;
    logic [22:0]             w_frac;
    logic [31:0]             r_res;
    logic                    r_inx;

    assign w_a = vals0[IN_LO +: IN_W];
    assign w_b = vals1[IN_LO +: IN_W];

    // S1: sign-extended add or subtract, one bit wider than the operands.
    // NOTE: stage data registers carry no reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge CLK) begin
      if (w_adv) begin
        r_sum <= MODE ? ($signed({w_a[IN_W-1], w_a}) - $signed({w_b[IN_W-1], w_b}))
                      : ($signed({w_a[IN_W-1], w_a}) + $signed({w_b[IN_W-1], w_b}));
      end
    end

    // S2 comb: magnitude; the most negative sum maps to 2^IN_W as an unsigned pattern.
    always_comb begin
      w_mag = r_sum[SUM_W-1] ? (~r_sum + SUM_W'(1)) : r_sum;
    end

    // S2: unsigned square of the magnitude.
    always_ff @(posedge CLK) begin
      if (w_adv) r_sq <= SQ_W'(w_mag) * SQ_W'(w_mag);
    end

    // S3 comb: leading-one detect (highest set bit wins).
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
      w_pos = '0;
      for (int i = 0; i < SQ_W; i++) begin
        if (r_sq[i]) w_pos = POS_W'(i);
      end
      w_shamt = POS_W'(SQ_W - 1) - w_pos;
    end

    // S3: left-normalise so the leading one sits in the top bit; keep the unbiased exponent biased by 127.
    always_ff @(posedge CLK) begin
      if (w_adv) begin
        r_norm <= r_sq << w_shamt;
        r_exp  <= 8'(w_pos) + 8'd127;
        r_nz   <= |r_sq;
      end
    end

    // S4 comb: round-to-nearest-even to 24 significand bits; a carry out bumps the exponent.
    always_comb begin
      w_ext     = {r_norm, 26'b0};
      w_man     = w_ext[EXT_W-1 -: 24];
      w_guard   = w_ext[EXT_W-25];
      w_sticky  = |w_ext[EXT_W-26:0];
      w_up      = w_guard & (w_sticky | w_man[0]);
      w_rnd     = {1'b0, w_man} + 25'(w_up);
      w_exp_fin = r_exp + 8'(w_rnd[24]);
      w_frac    = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    end

    // S4: packed result register; a zero square yields +0.0 exactly.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_res <= '0;
        r_inx <= 1'b0;
      end else if (w_adv) begin
        r_res <= r_nz ? {1'b0, w_exp_fin, w_frac} : 32'h0;
        r_inx <= r_nz & (w_guard | w_sticky);
      end
    end

    assign pipeout[OUT_LO +: 32] = r_res;
    assign inexact[LANES-1-l]    = r_inx;
  end

endmodule

// File: tb/tb_pipes_sqdiff_pipe.sv
// Self-checking bench for pipes_sqdiff_pipe: directed vector table with exact
// latency checks, reset-in-flight sequence, and a randomized backpressure run
// scored against an arithmetic reference model.
module tb_pipes_sqdiff_pipe;

  localparam int LANES = 16;
  localparam int IN_W  = 32;

  logic                  CLK = 1'b0;
  logic                  RST, EN, MODE, OUT_RDY;
  logic [LANES*IN_W-1:0] vals0, vals1;
  logic                  IN_RDY, OUT_VLD;
  logic [LANES*32-1:0]   pipeout;
  logic [LANES-1:0]      inexact;

  pipes_sqdiff_pipe #(.LANES(LANES), .IN_W(IN_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .IN_RDY(IN_RDY), .MODE(MODE),
    .vals0(vals0), .vals1(vals1), .pipeout(pipeout), .OUT_VLD(OUT_VLD),
    .OUT_RDY(OUT_RDY), .inexact(inexact)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: square as a wide integer, then round by integer division/remainder.
  function automatic logic [32:0] ref_fp(input longint a, input longint b, input logic m);
    longint      d;
    logic [65:0] mag, v, q, rem, half;
    int          p, sh;
    logic        inx;
    d   = m ? (a - b) : (a + b);
    mag = (d < 0) ? 66'(-d) : 66'(d);
    v   = mag * mag;
    if (v == 0) return 33'h0;
    p = 0;
    for (int i = 0; i < 66; i++) if (v[i]) p = i;
    if (p <= 23) return {1'b0, 1'b0, 8'(p + 127), 23'(v << (23 - p))};
    sh   = p - 23;
    q    = v >> sh;
    rem  = v - (q << sh);
    half = 66'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (66'd1 << 24)) begin
      q = q >> 1;
      p = p + 1;
    end
    return {inx, 1'b0, 8'(p + 127), 23'(q)};
  endfunction

  typedef struct {
    logic [LANES*32-1:0] pipe;
    logic [LANES-1:0]    inx;
  } res_t;

  function automatic res_t model(input logic [LANES*IN_W-1:0] x0, input logic [LANES*IN_W-1:0] x1, input logic m);
    res_t        r;
    logic [31:0] a, b;
    logic [32:0] f;
    for (int l = 0; l < LANES; l++) begin
      a = x0[(LANES-1-l)*IN_W +: IN_W];
      b = x1[(LANES-1-l)*IN_W +: IN_W];
      f = ref_fp(longint'($signed(a)), longint'($signed(b)), m);
      r.pipe[(LANES-1-l)*32 +: 32] = f[31:0];
      r.inx[LANES-1-l]             = f[32];
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 8192)) - 4096);
      2: case ($urandom_range(0, 3))
           0: return 32'h8000_0000;
           1: return 32'h7FFF_FFFF;
           2: return 32'h0;
           default: return 32'hFFFF_FFFF;
         endcase
      default: return 32'(67108863 + int'($urandom_range(0, 4)) - 2);
    endcase
  endfunction

  task automatic rnd_inputs();
    for (int l = 0; l < LANES; l++) begin
      vals0[l*IN_W +: IN_W] = rnd_op();
      vals1[l*IN_W +: IN_W] = rnd_op();
    end
    MODE = 1'($urandom_range(0, 1));
  endtask

  res_t sb_q[$];
  bit   sb_on     = 1'b0;
  bit   was_stall = 1'b0;
  res_t held;
  int   n_in = 0, n_out = 0;

  // One clock: observe at the falling edge (inputs already stable for the next
  // rising edge), then step past the rising edge.
  task automatic cycle();
    res_t exp_r;
    @(negedge CLK);
    if (was_stall) begin
      check("hold_vld",  OUT_VLD, 1'b1);
      check("hold_pipe", pipeout, held.pipe);
      check("hold_inx",  inexact, held.inx);
    end
    if (RST) check("rst_in_rdy", IN_RDY, 1'b1);
    else if (OUT_VLD && !OUT_RDY) check("stall_in_rdy", IN_RDY, 1'b0);
    if (sb_on) begin
      if (RST) sb_q.delete();
      else begin
        if (OUT_VLD && OUT_RDY) begin
          if (sb_q.size() == 0) check("unexpected_out", OUT_VLD, 1'b0);
          else begin
            exp_r = sb_q.pop_front();
            check("sb_pipe", pipeout, exp_r.pipe);
            check("sb_inx",  inexact, exp_r.inx);
            n_out++;
          end
        end
        if (EN && IN_RDY) begin
          sb_q.push_back(model(vals0, vals1, MODE));
          n_in++;
        end
      end
    end
    was_stall = OUT_VLD && !OUT_RDY && !RST;
    held.pipe = pipeout;
    held.inx  = inexact;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] exp_f;
    logic        exp_x;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0]  = '{"add_17_12",    32'd17,         32'd12,         1'b0, 32'h4452_4000, 1'b0};
    vecs[1]  = '{"sub_17_12",    32'd17,         32'd12,         1'b1, 32'h41C8_0000, 1'b0};
    vecs[2]  = '{"add_neg650",   32'hFFFF_FD76,  32'd633,        1'b0, 32'h4390_8000, 1'b0};
    vecs[3]  = '{"most_neg",     32'h8000_0000,  32'h8000_0000,  1'b0, 32'h5F80_0000, 1'b0};
    vecs[4]  = '{"zero",         32'd0,          32'd0,          1'b0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{"tie_even",     32'd4097,       32'd0,          1'b0, 32'h4B80_1000, 1'b1};
    vecs[6]  = '{"exact_24b",    32'd4095,       32'd0,          1'b0, 32'h4B7F_E001, 1'b0};
    vecs[7]  = '{"carry_exp",    32'd67108863,   32'd0,          1'b0, 32'h5980_0000, 1'b1};
    vecs[8]  = '{"span_sub",     32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 32'h5F80_0000, 1'b1};
    vecs[9]  = '{"sub_equal",    32'd123,        32'd123,        1'b1, 32'h0000_0000, 1'b0};
    vecs[10] = '{"one",          32'd0,          32'hFFFF_FFFF,  1'b0, 32'h3F80_0000, 1'b0};

    RST = 1'b1; EN = 1'b0; MODE = 1'b0; OUT_RDY = 1'b1; vals0 = '0; vals1 = '0;
    repeat (2) cycle();
    check("rst_out_vld", OUT_VLD, 1'b0);
    check("rst_pipeout", pipeout, '0);
    check("rst_inexact", inexact, '0);
    check("rst_in_rdy_hold", IN_RDY, 1'b1);

    // Directed table; the first beat is offered on the first edge after reset.
    RST = 1'b0;
    foreach (vecs[i]) begin
      vals0 = {LANES{vecs[i].a}};
      vals1 = {LANES{vecs[i].b}};
      MODE  = vecs[i].mode;
      EN    = 1'b1;
      check({vecs[i].name, "_in_rdy"}, IN_RDY, 1'b1);
      cycle();
      EN = 1'b0;
      repeat (2) begin
        cycle();
        check({vecs[i].name, "_early"}, OUT_VLD, 1'b0);
      end
      cycle();
      check({vecs[i].name, "_vld"}, OUT_VLD, 1'b1);
      check({vecs[i].name, "_pipe"}, pipeout, {LANES{vecs[i].exp_f}});
      check({vecs[i].name, "_inx"},  inexact, {LANES{vecs[i].exp_x}});
    end
    cycle();

    // Reset with beats in flight while the output is stalled.
    sb_on   = 1'b1;
    OUT_RDY = 1'b0;
    EN      = 1'b1;
    repeat (4) begin
      rnd_inputs();
      cycle();
    end
    EN = 1'b0;
    cycle();
    check("pre_rst_stalled", OUT_VLD, 1'b1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check("post_rst_vld", OUT_VLD, 1'b0);
    OUT_RDY = 1'b1;
    repeat (6) begin
      cycle();
      check("no_stale", OUT_VLD, 1'b0);
    end
    rnd_inputs();
    EN = 1'b1;
    cycle();
    EN = 1'b0;
    repeat (2) begin
      cycle();
      check("post_rst_early", OUT_VLD, 1'b0);
    end
    cycle();
    check("post_rst_latency", OUT_VLD, 1'b1);
    cycle();

    // Randomized traffic with random bubbles and backpressure.
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 3000; c++) begin
      rnd_inputs();
      EN      = ($urandom_range(0, 3) != 0);
      OUT_RDY = ($urandom_range(0, 2) != 0);
      cycle();
    end
    EN      = 1'b0;
    OUT_RDY = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) cycle();
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check("in_out_count", 32'(n_out), 32'(n_in));
    check("final_idle", OUT_VLD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
